// File: rtl/instruction_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Defines the fetch-buffer entry layout and the ROM/instruction geometry.
package instruction_fetch_pkg;

  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam int          IMEM_AW          = 7;
  localparam int          INSTR_W          = 32;
  localparam int          PC_W             = 32;

  typedef struct packed {
    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

endpackage

// File: rtl/fetch_buffer.sv
// Power-of-two FIFO of fetch entries with single-cycle flush; head shown combinationally.
// Zero added latency (written entry is visible the next cycle); push while full is legal only with a pop.
module fetch_buffer #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         flush,
  input  logic         push_vld,
  input  logic [W-1:0] push_dat,
  input  logic         pop,
  output logic         head_vld,
  output logic         full,
  output logic [W-1:0] head_dat
);

  localparam int         PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] DEPTH_C = (PW+1)'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          pop_eff;

  assign head_vld = (count_q != '0);
  assign full     = (count_q == DEPTH_C);
  assign pop_eff  = pop && head_vld;
  // Gated so the head reads as zero whenever nothing is buffered, including in reset.
  assign head_dat = head_vld ? mem_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_vld) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop_eff)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push_vld, pop_eff})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_vld && !flush) mem_q[wr_ptr_q] <= push_dat;
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: pc register drives the ROM, fetched {pc, instr} pairs queue for decode; redirect flushes.
// One-cycle fetch-to-present latency; pc stalls when the buffer is full and decode is not accepting.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
  parameter int          BUF_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_dout,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [PC_W-1:0]    if_pc
);

  logic [PC_W-1:0] pc_q, pc_d;
  logic            enq, deq, buf_full;
  fetch_entry_t    wr_entry, head_entry;

  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign wr_entry  = '{pc: pc_q, instr: imem_dout};
  assign deq       = if_valid && if_ready;

  // A full buffer can still take a new entry when the head leaves on the same edge.
  always_comb begin
    enq  = !redirect_valid && (!buf_full || deq);
    pc_d = pc_q;
    if (redirect_valid) pc_d = {redirect_pc[PC_W-1:2], 2'b00};
    else if (enq)       pc_d = pc_q + 32'd4;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pc_q <= RESET_PC;
    else        pc_q <= pc_d;
  end

  fetch_buffer #(
    .DEPTH (BUF_DEPTH),
    .W     (FETCH_ENTRY_W)
  ) u_fetch_buffer (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (redirect_valid),
    .push_vld (enq),
    .push_dat (wr_entry),
    .pop      (deq),
    .head_vld (if_valid),
    .full     (buf_full),
    .head_dat (head_entry)
  );

  assign if_instr = head_entry.instr;
  assign if_pc    = head_entry.pc;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: free-run, stall, redirect, wrap, async reset, redirect/handshake.
module tb_instruction_fetch;

  logic        clk;
  logic        rst_n;
  logic [6:0]  imem_addr;
  logic [31:0] imem_dout;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        if_valid;
  logic        if_ready;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  int n_cmp = 0;
  int n_err = 0;
  int acc_cnt = 0;

  localparam logic [31:0] ROM_BASE = 32'h1000_0000;

  instruction_fetch dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_addr      (imem_addr),
    .imem_dout      (imem_dout),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .if_valid       (if_valid),
    .if_ready       (if_ready),
    .if_instr       (if_instr),
    .if_pc          (if_pc)
  );

  // ROM word k holds ROM_BASE + k.
  assign imem_dout = ROM_BASE + {25'd0, imem_addr};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && if_valid && if_ready) acc_cnt = acc_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_head(input string tag, input logic [31:0] exp_pc);
    chk({tag, ".valid"}, {31'd0, if_valid}, 32'd1);
    chk({tag, ".pc"}, if_pc, exp_pc);
    chk({tag, ".instr"}, if_instr, ROM_BASE + {25'd0, exp_pc[8:2]});
  endtask

  initial begin
    rst_n          = 1'b0;
    if_ready       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst.valid", {31'd0, if_valid}, 32'd0);
    chk("rst.pc", if_pc, 32'd0);
    chk("rst.instr", if_instr, 32'd0);
    chk("rst.addr", {25'd0, imem_addr}, 32'd0);

    // Free run: head advances 0,4,8,... one per cycle
    rst_n    = 1'b1;
    if_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_head("run", 32'(4 * k));
    end

    // Backpressure: buffer {20,24} fills, pc holds at 28 (word 7)
    if_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_head("stall", 32'd20);
    end
    chk("stall.addr", {25'd0, imem_addr}, 32'd7);

    // Release: resumes at 24 with no gap or duplicate
    if_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk_head("resume", 32'(24 + 4 * k));
    end

    // Redirect to 0x43 with a full buffer and no handshake
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0043;
    tick();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    chk("redir.flush", {31'd0, if_valid}, 32'd0);
    chk("redir.addr", {25'd0, imem_addr}, 32'd16);
    tick();
    chk_head("redir.tgt", 32'h40);
    tick();
    chk_head("redir.next", 32'h44);

    // Wrap: 0x1FC then 0x200, ROM address 127 then 0
    if_ready       = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_01FC;
    tick();
    redirect_valid = 1'b0;
    if_ready       = 1'b1;
    chk("wrap.addr127", {25'd0, imem_addr}, 32'd127);
    tick();
    chk_head("wrap.1fc", 32'h1FC);
    chk("wrap.addr0", {25'd0, imem_addr}, 32'd0);
    tick();
    chk_head("wrap.200", 32'h200);

    // Mid-run async reset with a full buffer
    if_ready = 1'b0;
    tick();
    chk_head("prerst", 32'h200);
    #1 rst_n = 1'b0;
    #1;
    chk("arst.valid", {31'd0, if_valid}, 32'd0);
    chk("arst.pc", if_pc, 32'd0);
    chk("arst.addr", {25'd0, imem_addr}, 32'd0);
    #4 rst_n = 1'b1;
    if_ready = 1'b1;
    tick();
    chk_head("restart0", 32'd0);
    tick();
    chk_head("restart4", 32'd4);

    // Redirect coinciding with a handshake, then back-to-back redirect
    acc_cnt        = 0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h10;
    tick();
    redirect_pc = 32'h20;
    tick();
    redirect_valid = 1'b0;
    chk("b2b.flush", {31'd0, if_valid}, 32'd0);
    chk("b2b.addr", {25'd0, imem_addr}, 32'd8);
    tick();
    chk_head("b2b.tgt", 32'h20);
    chk("b2b.accepts", 32'(acc_cnt), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, byte address of the first fetch after reset.
REQ-002 Parameter BUF_DEPTH, default 2, number of fetch-buffer entries; legal values are 2 and 4.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  reset; asynchronous, active-low.
REQ-005 imem_addr  output  7  word address to the instruction ROM, equal to pc[8:2].
REQ-006 imem_dout  input  32  ROM read data; combinational, valid in the same cycle as imem_addr.
REQ-007 redirect_valid  input  1  branch/jump redirect request.
REQ-008 redirect_pc  input  32  redirect target byte address.
REQ-009 if_valid  output  1  a fetched instruction is presented to decode.
REQ-010 if_ready  input  1  decode accepts the presented instruction.
REQ-011 if_instr  output  32  fetched instruction word.
REQ-012 if_pc  output  32  byte address of if_instr.

Function
REQ-013 The block SHALL hold a 32-bit pc register; imem_addr SHALL be driven combinationally from pc[8:2].
REQ-014 The fetch buffer SHALL be a FIFO of BUF_DEPTH entries, each holding {pc, instr}.
REQ-015 Enqueue SHALL occur when redirect_valid=0 and (count<BUF_DEPTH or a dequeue occurs in the same cycle); the entry written SHALL be {pc, imem_dout}.
REQ-016 On every enqueue, pc SHALL advance by 4 modulo 2^32; imem_addr therefore wraps from 127 to 0.
REQ-017 Dequeue SHALL occur when if_valid=1 and if_ready=1.
REQ-018 if_valid SHALL equal (count!=0); if_instr and if_pc SHALL show the head entry and SHALL stay stable while if_valid=1 and if_ready=0.
REQ-019 Minimum latency: an instruction fetched at the edge ending cycle N SHALL be presented in cycle N+1.
REQ-020 When the buffer is full and no dequeue occurs, pc SHALL hold and no entry SHALL be written.
REQ-021 When the buffer is empty, a dequeue SHALL be impossible, because if_valid=0.
REQ-022 When redirect_valid=1, on that edge the block SHALL:
- discard all buffered entries (count set to 0);
- load pc with {redirect_pc[31:2], 2'b00};
- perform no enqueue.
REQ-023 A handshake coinciding with redirect_valid=1 SHALL still count as accepted by decode, and the flush SHALL take priority for buffer state.
REQ-024 The instruction at the redirect target SHALL be presented in the cycle after the redirect edge.
REQ-025 Back-to-back redirects SHALL each take effect; the last one determines pc.
REQ-026 Simultaneous enqueue and dequeue SHALL leave count unchanged, including when the buffer is full.
REQ-027 The block SHALL NOT decode instructions and SHALL NOT alter instruction data.

Reset
REQ-028 While rst_n=0: pc=RESET_PC, count=0, read/write pointers=0, if_valid=0, if_instr=0, if_pc=0, and imem_addr=RESET_PC[8:2].
REQ-029 Assertion of rst_n mid-operation SHALL discard buffered entries immediately, without waiting for a clock edge.
REQ-030 Reset SHALL be released synchronously to clk externally; fetch SHALL begin on the first rising edge with rst_n=1.

Structure
REQ-031 A shared package SHALL hold:
- the default RESET_PC;
- the ROM address width (7);
- the instruction width (32);
- the fetch-entry struct {pc, instr}.
REQ-032 The FIFO SHALL be a sub-module named fetch_buffer, parameterised by depth and entry width, with a flush input.
REQ-033 The pc register, enqueue/dequeue control and redirect logic SHALL reside in instruction_fetch.

Verification
REQ-034 Free-run: ROM word k = 32'h1000_0000+k, if_ready=1 after reset -> if_pc=0,4,8,… and if_instr=32'h1000_0000,… on consecutive cycles, starting the cycle after the first edge.
REQ-035 Backpressure: hold if_ready=0 for 5 cycles -> count saturates at BUF_DEPTH and pc holds at 4*BUF_DEPTH; if_pc=0 stays stable; on release, the sequence resumes with no gap or duplicate.
REQ-036 Redirect: redirect_pc=32'h0000_0043 while the buffer is full -> next cycle if_pc=32'h40 and if_instr=ROM[16]; no stale entries appear afterwards.
REQ-037 Wrap: redirect to 32'h1FC -> if_pc 32'h1FC then 32'h200, with imem_addr 127 then 0, and if_instr=ROM[127] then ROM[0].
REQ-038 Mid-run async reset: pulse rst_n low for half a cycle with the buffer full -> if_valid drops immediately; after release, the fetch restarts at RESET_PC.
REQ-039 Redirect coinciding with a handshake plus back-to-back redirects to 32'h10 then 32'h20 -> one accept is counted and the next presented if_pc=32'h20.
